// File: rtl/sliding_door_anim.sv
// Sliding-door bar animation: opens from the centre outward, holds, then closes.
// Define DOOR_OBSTRUCT_EN to let the obstruct input reverse closing and freeze the open hold.
module sliding_door_anim #(
  parameter int unsigned N_LEDS      = 10,
  parameter int unsigned STEP_CYCLES = 5000000,
  parameter int unsigned HOLD_STEPS  = 20
) (
  input  logic              clk,
  input  logic              rst_s_p,
  input  logic              open_btn,
  input  logic              pass,
  input  logic              obstruct,
  output logic [N_LEDS-1:0] leds,
  output logic              person_in,
  output logic [1:0]        state
);

  localparam int unsigned HALF = (N_LEDS + 1) / 2;
  localparam int unsigned PW   = $clog2(HALF + 1);
  localparam int unsigned TW   = $clog2(STEP_CYCLES + 1);
  localparam int unsigned HW   = $clog2(HOLD_STEPS + 1);

  typedef enum logic [1:0] {
    CLOSED  = 2'b00,
    OPENING = 2'b01,
    OPEN    = 2'b10,
    CLOSING = 2'b11
  } state_e;

  state_e            state_q;
  logic [PW-1:0]     pos_q, pos_d;
  logic [TW-1:0]     timer_q;
  logic [HW-1:0]     hold_q;
  logic [N_LEDS-1:0] leds_q;
  logic              person_q;
  logic              btn_q;
  logic              armed_q;
  logic              req_c, tick_c, rev_c, obs_open_c;

  // Segment i stays lit while its distance from the nearer edge is below HALF - pos.
  function automatic logic [N_LEDS-1:0] bar_of(input logic [PW-1:0] p);
    logic [N_LEDS-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < N_LEDS; i++) begin
      if (((i < N_LEDS - 1 - i) ? i : N_LEDS - 1 - i) + 32'(p) < HALF) b[i] = 1'b1;
    end
    return b;
  endfunction

`ifdef DOOR_OBSTRUCT_EN
  assign obs_open_c = obstruct && (state_q == OPEN);
  assign rev_c      = req_c || (obstruct && (state_q == CLOSING));
`else
  logic unused_obstruct;
  assign unused_obstruct = obstruct;
  assign obs_open_c      = 1'b0;
  assign rev_c           = req_c;
`endif

  // armed_q masks the first cycle after reset so a held button is not seen as an edge.
  assign req_c  = armed_q && open_btn && !btn_q;
  assign tick_c = (state_q != CLOSED) && (timer_q == TW'(STEP_CYCLES - 1));

  // Position datapath; a reversal in CLOSING suppresses that cycle's decrement.
  always_comb begin
    pos_d = pos_q;
    case (state_q)
      OPENING: if (tick_c && (pos_q < PW'(HALF))) pos_d = pos_q + PW'(1);
      CLOSING: if (!rev_c && tick_c && (pos_q != '0)) pos_d = pos_q - PW'(1);
      default: pos_d = pos_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_s_p) begin
      state_q  <= CLOSED;
      pos_q    <= '0;
      leds_q   <= '1;
      person_q <= 1'b0;
      timer_q  <= '0;
      hold_q   <= '0;
      btn_q    <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      btn_q   <= open_btn;
      armed_q <= 1'b1;
      pos_q   <= pos_d;
      leds_q  <= bar_of(pos_d);
      if (tick_c || (state_q == CLOSED)) timer_q <= '0;
      else timer_q <= timer_q + TW'(1);

      // Every state change below also restarts the step timer.
      case (state_q)
        CLOSED: begin
          if (req_c) begin
            state_q <= OPENING;
            timer_q <= '0;
          end
        end
        OPENING: begin
          if (tick_c && (pos_d == PW'(HALF))) begin
            state_q <= OPEN;
            timer_q <= '0;
            hold_q  <= '0;
          end
        end
        OPEN: begin
          if (pass) person_q <= !person_q;
          if (obs_open_c || req_c) begin
            hold_q <= '0;
          end else if (tick_c) begin
            if (hold_q == HW'(HOLD_STEPS - 1)) begin
              state_q <= CLOSING;
              timer_q <= '0;
              hold_q  <= '0;
            end else begin
              hold_q <= hold_q + HW'(1);
            end
          end
        end
        CLOSING: begin
          if (rev_c) begin
            state_q <= OPENING;
            timer_q <= '0;
          end else if (tick_c && (pos_d == '0)) begin
            state_q <= CLOSED;
            timer_q <= '0;
          end
        end
        default: state_q <= CLOSED;
      endcase
    end
  end

  assign leds      = leds_q;
  assign person_in = person_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sliding_door_anim.sv
// Directed table-driven bench for sliding_door_anim (N_LEDS=10, STEP_CYCLES=4, HOLD_STEPS=3).
module tb_sliding_door_anim;

  logic       clk = 1'b0;
  logic       rst_s_p = 1'b1;
  logic       open_btn = 1'b0;
  logic       pass = 1'b0;
  logic       obstruct = 1'b0;
  logic [9:0] leds;
  logic       person_in;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  sliding_door_anim #(.N_LEDS(10), .STEP_CYCLES(4), .HOLD_STEPS(3)) dut (
    .clk(clk), .rst_s_p(rst_s_p), .open_btn(open_btn), .pass(pass), .obstruct(obstruct),
    .leds(leds), .person_in(person_in), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, btn, ps, obs;
    int         n;
    logic [1:0] st;
    logic [9:0] ld;
    logic       per;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic btn, input logic ps, input logic obs,
                              input int n, input logic [1:0] st, input logic [9:0] ld,
                              input logic per);
    vec_t v;
    v.rst = rst; v.btn = btn; v.ps = ps; v.obs = obs; v.n = n;
    v.st = st; v.ld = ld; v.per = per;
    vecs.push_back(v);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] st, input logic [9:0] ld,
                       input logic per);
    total++;
    if (state !== st || leds !== ld || person_in !== per) begin
      bad++;
      $display("FAIL %s: got state=%b leds=%h person=%b, want state=%b leds=%h person=%b",
               name, state, leds, person_in, st, ld, per);
    end
  endtask

  task automatic drive(input logic rst, input logic btn, input logic ps, input logic obs);
    rst_s_p = rst; open_btn = btn; pass = ps; obstruct = obs;
  endtask

  initial begin
    int waited;
    // Open sequence, centre-out: pos1=3CF pos2=387 pos3=303 pos4=201 pos5=000
    add(1,0,0,0, 1, 2'b00, 10'h3FF, 0);
    add(0,0,0,0, 1, 2'b00, 10'h3FF, 0);
    add(0,1,0,0, 1, 2'b01, 10'h3FF, 0);
    add(0,1,0,0, 3, 2'b01, 10'h3FF, 0);
    add(0,0,0,0, 1, 2'b01, 10'h3CF, 0);
    add(0,0,1,0, 1, 2'b01, 10'h3CF, 0);
    add(0,0,0,0, 3, 2'b01, 10'h387, 0);
    add(0,0,0,0, 4, 2'b01, 10'h303, 0);
    add(0,0,0,0, 4, 2'b01, 10'h201, 0);
    add(0,0,0,0, 3, 2'b01, 10'h201, 0);
    add(0,0,0,0, 1, 2'b10, 10'h000, 0);
    // Occupancy toggles in OPEN, then hold restart by a request edge
    add(0,0,1,0, 1, 2'b10, 10'h000, 1);
    add(0,0,0,0, 1, 2'b10, 10'h000, 1);
    add(0,0,1,0, 1, 2'b10, 10'h000, 0);
    add(0,0,0,0, 1, 2'b10, 10'h000, 0);
    add(0,1,0,0, 1, 2'b10, 10'h000, 0);
    add(0,0,0,0, 6, 2'b10, 10'h000, 0);
    add(0,0,0,0, 4, 2'b10, 10'h000, 0);
    add(0,0,0,0, 1, 2'b11, 10'h000, 0);
    add(0,0,0,0, 4, 2'b11, 10'h201, 0);
    add(0,0,0,0, 4, 2'b11, 10'h303, 0);
    // Reversal at pos 3 keeps position
    add(0,1,0,0, 1, 2'b01, 10'h303, 0);
    add(0,1,0,0, 3, 2'b01, 10'h303, 0);
    add(0,0,0,0, 1, 2'b01, 10'h201, 0);
    add(0,0,0,0, 4, 2'b10, 10'h000, 0);
    // Reversal on the same cycle as a closing tick: no decrement
    add(0,0,0,0, 11, 2'b10, 10'h000, 0);
    add(0,0,0,0, 1, 2'b11, 10'h000, 0);
    add(0,0,0,0, 3, 2'b11, 10'h000, 0);
    add(0,1,0,0, 1, 2'b01, 10'h000, 0);
    add(0,0,0,0, 3, 2'b01, 10'h000, 0);
    add(0,0,0,0, 1, 2'b10, 10'h000, 0);
`ifdef DOOR_OBSTRUCT_EN
    add(0,0,0,1, 11, 2'b10, 10'h000, 0);
    add(0,0,0,1, 1, 2'b10, 10'h000, 0);
    add(0,0,0,0, 11, 2'b10, 10'h000, 0);
    add(0,0,0,0, 1, 2'b11, 10'h000, 0);
`else
    add(0,0,0,1, 11, 2'b10, 10'h000, 0);
    add(0,0,0,1, 1, 2'b11, 10'h000, 0);
    add(0,0,0,1, 4, 2'b11, 10'h201, 0);
    add(0,0,0,0, 16, 2'b00, 10'h3FF, 0);
`endif

    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].btn, vecs[i].ps, vecs[i].obs);
      cycles(vecs[i].n);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].ld, vecs[i].per);
    end

    // Reset mid-opening with the button held: immediate close, no reopen until a new edge
    drive(1,0,0,0); cycles(1);
    drive(0,0,0,0); cycles(1);
    drive(0,1,0,0); cycles(1);
    check("reopen_start", 2'b01, 10'h3FF, 0);
    cycles(4);
    check("reopen_pos1", 2'b01, 10'h3CF, 0);
    drive(1,1,0,0); cycles(1);
    check("rst_mid_anim", 2'b00, 10'h3FF, 0);
    drive(0,1,0,0); cycles(1);
    check("rst_release_held", 2'b00, 10'h3FF, 0);
    cycles(6);
    check("still_closed_held", 2'b00, 10'h3FF, 0);
    drive(0,0,0,0); cycles(1);
    drive(0,1,0,0); cycles(1);
    check("new_edge_opens", 2'b01, 10'h3FF, 0);

    // Bounded wait for OPEN: opening must take exactly 20 cycles
    drive(0,0,0,0);
    waited = 0;
    while (state !== 2'b10 && waited < 40) begin
      cycles(1);
      waited++;
    end
    total++;
    if (waited != 20) begin
      bad++;
      $display("FAIL open_latency: got %0d cycles, want 20", waited);
    end
    check("open_reached", 2'b10, 10'h000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
